water_reminder_timer: RTL and testbench
=======================================

# water_reminder_timer

Reminder countdown core for the water-reminder design. Counts down a user-selected interval in whole minutes and presents the remaining minutes as a 6-bit binary value, clamped to 0–31, to the downstream binary-to-BCD decode and display path. On expiry it raises a blinking alert. The alert holds until the user acknowledges it, then the timer automatically re-arms for the same interval.

## Interface
- `CLK_HZ`, default 50_000_000: clock cycles per 1 s tick.
- `SECS_PER_MIN`, default 60: ticks per decrement of `remaining`.
- `clk` in 1: system clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse that loads `interval_sel` and begins counting.
- `stop` in 1: one-cycle pulse that aborts to idle.
- `ack` in 1: one-cycle pulse that acknowledges the alert.
- `interval_sel` in 6: requested interval in minutes; values above 31 are clamped to 31.
- `remaining` out 6: minutes left, 0–31, registered.
- `running` out 1: high in COUNT.
- `alert` out 1: high in ALERT.
- `alert_blink` out 1: in ALERT, toggles on every tick; low otherwise.

All control inputs are synchronous, debounced, single-cycle pulses produced upstream.

## Operation
- States (shared enum): IDLE, COUNT, ALERT.
- Reset: state=IDLE, `remaining`=0, `running`=0, `alert`=0, `alert_blink`=0, prescaler=0, second counter=0, stored interval=0.
- Clamp: eff = (`interval_sel` > 31) ? 31 : `interval_sel`.
- IDLE:
  - `start` with eff ≠ 0: store eff, `remaining`=eff, clear prescaler and second counter, go to COUNT.
  - `start` with eff = 0: ignored.
- COUNT:
  - Prescaler counts 0..CLK_HZ-1; the wrap cycle is a tick.
  - On a tick, the second counter increments; when it reaches SECS_PER_MIN-1 on a tick it wraps to 0 and `remaining` decrements.
  - When `remaining` decrements 1→0, the same edge enters ALERT.
- ALERT:
  - `remaining` holds 0.
  - Prescaler keeps running.
  - `alert_blink` starts at 0 on entry and toggles each tick.
  - `ack`: reload `remaining` from the stored interval, clear the counters and `alert_blink`, return to COUNT.
- Priority, highest first: `stop` > `start` > `ack` > tick.
  - `stop` in any state: go to IDLE, `remaining`=0, counters cleared.
  - `start` in COUNT or ALERT: restart with the new eff. Eff = 0 here behaves like `stop`.
  - `ack` in IDLE or COUNT: ignored.
  - A tick in the same cycle as `start`, `stop` or `ack` is discarded.
- Arithmetic:
  - Prescaler width is $clog2(CLK_HZ).
  - Second counter width is $clog2(SECS_PER_MIN).
  - `remaining` never underflows and never exceeds 31.

## Timing
- All outputs are registered and change on the rising edge after the cause.
- `start` sampled at edge N: `remaining`=eff and `running`=1 from edge N.
- First tick: CLK_HZ cycles after the accepting edge.
- First decrement: CLK_HZ·SECS_PER_MIN cycles after start.
- Expiry: `alert` rises exactly eff·CLK_HZ·SECS_PER_MIN cycles after the start edge, on the same edge `remaining` becomes 0.
- `ack` at edge M: `alert`=0, `running`=1, `remaining`=stored interval from edge M.
- `reset_n` low clears everything immediately, regardless of clock; it may arrive mid-count or mid-alert. The first `start` is accepted on the first edge after deassertion.

## Structure
- Package `water_pkg`:
  - `typedef enum logic [1:0] {IDLE, COUNT, ALERT} timer_state_t`
  - `localparam MAX_MINUTES = 31`
  - `localparam REMAIN_W = 6`
- Sub-module `tick_prescaler`:
  - Parameter CLK_HZ.
  - Ports `clk`, `reset_n`, `clear`, `tick`.
  - Produces the one-cycle tick.
- The FSM, second counter and minute counter live in `water_reminder_timer`.

## Test plan
All scenarios use CLK_HZ=4 and SECS_PER_MIN=3, i.e. 12 cycles per minute.
- Basic countdown: `start` with `interval_sel`=2.
  - `remaining`=2 immediately, 1 after 12 cycles.
  - `remaining`=0 with `alert`=1 after 24 cycles.
  - `alert_blink` toggles every 4 cycles.
- Clamp and zero:
  - `interval_sel`=45 gives `remaining`=31.
  - `interval_sel`=0 in IDLE leaves state IDLE and `remaining`=0.
- Ack re-arm: in ALERT, `ack` with `interval_sel`=2 stored.
  - `alert`=0, `remaining`=2, `running`=1.
  - Expires again 24 cycles later.
- Priority: pulse `stop` and `start` in the same cycle during COUNT gives IDLE, `remaining`=0. `ack` during COUNT changes nothing.
- Restart on tick: `start` with `interval_sel`=5 mid-count, on the tick cycle.
  - `remaining`=5.
  - First decrement exactly 12 cycles later.
- Async reset: drop `reset_n` mid-ALERT between clock edges. All outputs go to 0 before the next edge.

Source files
------------

// File: rtl/water_pkg.sv
// Shared types and constants for the water-reminder countdown core.
// Holds the timer state enum, the minute limit and the minute-clamp helper.
package water_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        ALERT
    } timer_state_t;

    localparam int MAX_MINUTES = 31;
    localparam int REMAIN_W    = 6;

    // Requests above the displayable range saturate at MAX_MINUTES.
    function automatic logic [REMAIN_W-1:0] clamp_minutes(
        input logic [REMAIN_W-1:0] sel
    );
        return (sel > REMAIN_W'(MAX_MINUTES)) ? REMAIN_W'(MAX_MINUTES) : sel;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// One-second tick generator: counts 0..CLK_HZ-1, tick is high on the wrap cycle.
// Ports: clk, reset_n (async low), clear (restart from 0), tick (1-cycle pulse).
module tick_prescaler #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_HZ - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clear || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/water_reminder_timer.sv
// Water-reminder countdown: minutes down from a clamped interval, then blinking alert.
// Ports: clk, reset_n, start/stop/ack pulses, interval_sel -> remaining, running, alert, alert_blink.
module water_reminder_timer
    import water_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
    parameter int SECS_PER_MIN = 60
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                stop,
    input  logic                ack,
    input  logic [REMAIN_W-1:0] interval_sel,
    output logic [REMAIN_W-1:0] remaining,
    output logic                running,
    output logic                alert,
    output logic                alert_blink
);

    localparam int SEC_W = (SECS_PER_MIN > 1) ? $clog2(SECS_PER_MIN) : 1;
    localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(SECS_PER_MIN - 1);

    timer_state_t        state;
    logic [SEC_W-1:0]    sec_cnt;
    logic [REMAIN_W-1:0] stored;
    logic [REMAIN_W-1:0] eff;
    logic                tick;
    logic                abort;
    logic                ack_hit;
    logic                clear;

    assign eff     = clamp_minutes(interval_sel);
    // A start with a zero interval is treated as an abort in every state.
    assign abort   = stop | (start & (eff == '0));
    assign ack_hit = ack & (state == ALERT);
    // Any accepted control pulse restarts the second phase from zero.
    assign clear   = (state == IDLE) | start | stop | ack_hit;

    tick_prescaler #(
        .CLK_HZ(CLK_HZ)
    ) u_prescaler (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (clear),
        .tick   (tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            sec_cnt     <= '0;
            stored      <= '0;
            remaining   <= '0;
            running     <= 1'b0;
            alert       <= 1'b0;
            alert_blink <= 1'b0;
        end else if (abort) begin
            state       <= IDLE;
            sec_cnt     <= '0;
            remaining   <= '0;
            running     <= 1'b0;
            alert       <= 1'b0;
            alert_blink <= 1'b0;
        end else if (start) begin
            state       <= COUNT;
            sec_cnt     <= '0;
            stored      <= eff;
            remaining   <= eff;
            running     <= 1'b1;
            alert       <= 1'b0;
            alert_blink <= 1'b0;
        end else if (ack_hit) begin
            state       <= COUNT;
            sec_cnt     <= '0;
            remaining   <= stored;
            running     <= 1'b1;
            alert       <= 1'b0;
            alert_blink <= 1'b0;
        end else if (tick) begin
            unique case (state)
                COUNT: begin
                    if (sec_cnt == SEC_LAST) begin
                        sec_cnt <= '0;
                        if (remaining <= REMAIN_W'(1)) begin
                            state       <= ALERT;
                            remaining   <= '0;
                            running     <= 1'b0;
                            alert       <= 1'b1;
                            alert_blink <= 1'b0;
                        end else begin
                            remaining <= remaining - REMAIN_W'(1);
                        end
                    end else begin
                        sec_cnt <= sec_cnt + SEC_W'(1);
                    end
                end
                ALERT: begin
                    alert_blink <= ~alert_blink;
                end
                IDLE: begin
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_water_reminder_timer.sv
// Scoreboard bench for water_reminder_timer at CLK_HZ=4, SECS_PER_MIN=3.
// Expectations are queued per cycle and popped when that cycle's outputs settle.
module tb_water_reminder_timer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       ack = 1'b0;
    logic [5:0] interval_sel = '0;
    logic [5:0] remaining;
    logic       running;
    logic       alert;
    logic       alert_blink;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        string      name;
        int         at;
        logic [8:0] val;
    } exp_t;

    exp_t q[$];

    water_reminder_timer #(
        .CLK_HZ      (4),
        .SECS_PER_MIN(3)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .stop        (stop),
        .ack         (ack),
        .interval_sel(interval_sel),
        .remaining   (remaining),
        .running     (running),
        .alert       (alert),
        .alert_blink (alert_blink)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [8:0] pk(input int r, input bit run, input bit alt, input bit blk);
        return {6'(r), run, alt, blk};
    endfunction

    task automatic expect_at(input string n, input int at, input logic [8:0] v);
        q.push_back('{n, at, v});
    endtask

    // Pulse the given controls so they are sampled on edge number e.
    task automatic drive_at(input int e, input logic s, input logic p,
                            input logic a, input logic [5:0] sel);
        while (cyc < e - 1) @(negedge clk);
        start = s;
        stop = p;
        ack = a;
        interval_sel = sel;
        @(posedge clk);
        #1;
        start = 1'b0;
        stop = 1'b0;
        ack = 1'b0;
    endtask

    task automatic test_reset;
        exp_t e;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({remaining, running, alert, alert_blink} !== 9'h000) begin
            errors++;
            $display("FAIL reset_hold got=%h exp=%h",
                     {remaining, running, alert, alert_blink}, 9'h000);
        end
        reset_n = 1'b1;
        expect_at("idle_ack", cyc + 2, pk(0, 0, 0, 0));
        expect_at("idle_later", cyc + 5, pk(0, 0, 0, 0));
        fork
            drive_at(cyc + 2, 1'b0, 1'b0, 1'b1, 6'd3);
            while (q.size() > 0) begin
                @(negedge clk);
                while (q.size() > 0 && q[0].at <= cyc) begin
                    e = q.pop_front();
                    checks++;
                    if ({remaining, running, alert, alert_blink} !== e.val || e.at != cyc) begin
                        errors++;
                        $display("FAIL %s cyc=%0d got=%h exp=%h", e.name, cyc,
                                 {remaining, running, alert, alert_blink}, e.val);
                    end
                end
            end
        join
    endtask

    task automatic test_basic;
        exp_t e;
        int b;
        b = cyc + 2;
        expect_at("basic_load", b, pk(2, 1, 0, 0));
        expect_at("basic_pre_dec", b + 11, pk(2, 1, 0, 0));
        expect_at("basic_dec", b + 12, pk(1, 1, 0, 0));
        expect_at("basic_pre_exp", b + 23, pk(1, 1, 0, 0));
        expect_at("basic_expire", b + 24, pk(0, 0, 1, 0));
        expect_at("blink_hold0", b + 27, pk(0, 0, 1, 0));
        expect_at("blink_1", b + 28, pk(0, 0, 1, 1));
        expect_at("blink_hold1", b + 31, pk(0, 0, 1, 1));
        expect_at("blink_0", b + 32, pk(0, 0, 1, 0));
        expect_at("blink_1b", b + 36, pk(0, 0, 1, 1));
        fork
            drive_at(b, 1'b1, 1'b0, 1'b0, 6'd2);
            while (q.size() > 0) begin
                @(negedge clk);
                while (q.size() > 0 && q[0].at <= cyc) begin
                    e = q.pop_front();
                    checks++;
                    if ({remaining, running, alert, alert_blink} !== e.val || e.at != cyc) begin
                        errors++;
                        $display("FAIL %s cyc=%0d got=%h exp=%h", e.name, cyc,
                                 {remaining, running, alert, alert_blink}, e.val);
                    end
                end
            end
        join
    endtask

    task automatic test_ack_rearm;
        exp_t e;
        int b;
        b = cyc + 2;
        expect_at("ack_reload", b, pk(2, 1, 0, 0));
        expect_at("ack_dec", b + 12, pk(1, 1, 0, 0));
        expect_at("ack_pre_exp", b + 23, pk(1, 1, 0, 0));
        expect_at("ack_expire", b + 24, pk(0, 0, 1, 0));
        fork
            drive_at(b, 1'b0, 1'b0, 1'b1, 6'd9);
            while (q.size() > 0) begin
                @(negedge clk);
                while (q.size() > 0 && q[0].at <= cyc) begin
                    e = q.pop_front();
                    checks++;
                    if ({remaining, running, alert, alert_blink} !== e.val || e.at != cyc) begin
                        errors++;
                        $display("FAIL %s cyc=%0d got=%h exp=%h", e.name, cyc,
                                 {remaining, running, alert, alert_blink}, e.val);
                    end
                end
            end
        join
    endtask

    task automatic test_priority;
        exp_t e;
        int b;
        b = cyc + 2;
        expect_at("prio_load", b, pk(3, 1, 0, 0));
        expect_at("prio_ack_ign", b + 5, pk(3, 1, 0, 0));
        expect_at("prio_pre_dec", b + 11, pk(3, 1, 0, 0));
        expect_at("prio_dec", b + 12, pk(2, 1, 0, 0));
        expect_at("prio_stop_start", b + 14, pk(0, 0, 0, 0));
        expect_at("prio_idle", b + 30, pk(0, 0, 0, 0));
        fork
            begin
                drive_at(b, 1'b1, 1'b0, 1'b0, 6'd3);
                drive_at(b + 5, 1'b0, 1'b0, 1'b1, 6'd3);
                drive_at(b + 14, 1'b1, 1'b1, 1'b0, 6'd4);
            end
            while (q.size() > 0) begin
                @(negedge clk);
                while (q.size() > 0 && q[0].at <= cyc) begin
                    e = q.pop_front();
                    checks++;
                    if ({remaining, running, alert, alert_blink} !== e.val || e.at != cyc) begin
                        errors++;
                        $display("FAIL %s cyc=%0d got=%h exp=%h", e.name, cyc,
                                 {remaining, running, alert, alert_blink}, e.val);
                    end
                end
            end
        join
    endtask

    task automatic test_restart_on_tick;
        exp_t e;
        int b;
        b = cyc + 2;
        expect_at("rst_load7", b + 7, pk(7, 1, 0, 0));
        expect_at("rst_load5", b + 8, pk(5, 1, 0, 0));
        expect_at("rst_pre_dec", b + 19, pk(5, 1, 0, 0));
        expect_at("rst_dec", b + 20, pk(4, 1, 0, 0));
        fork
            begin
                drive_at(b, 1'b1, 1'b0, 1'b0, 6'd7);
                drive_at(b + 8, 1'b1, 1'b0, 1'b0, 6'd5);
            end
            while (q.size() > 0) begin
                @(negedge clk);
                while (q.size() > 0 && q[0].at <= cyc) begin
                    e = q.pop_front();
                    checks++;
                    if ({remaining, running, alert, alert_blink} !== e.val || e.at != cyc) begin
                        errors++;
                        $display("FAIL %s cyc=%0d got=%h exp=%h", e.name, cyc,
                                 {remaining, running, alert, alert_blink}, e.val);
                    end
                end
            end
        join
    endtask

    task automatic test_clamp_zero;
        exp_t e;
        int b;
        b = cyc + 2;
        expect_at("clamp45", b, pk(31, 1, 0, 0));
        expect_at("clamp_pre_dec", b + 11, pk(31, 1, 0, 0));
        expect_at("clamp_dec", b + 12, pk(30, 1, 0, 0));
        expect_at("stop_idle", b + 13, pk(0, 0, 0, 0));
        expect_at("zero_idle", b + 15, pk(0, 0, 0, 0));
        expect_at("zero_idle_later", b + 20, pk(0, 0, 0, 0));
        expect_at("clamp32", b + 21, pk(31, 1, 0, 0));
        expect_at("zero_in_count", b + 23, pk(0, 0, 0, 0));
        fork
            begin
                drive_at(b, 1'b1, 1'b0, 1'b0, 6'd45);
                drive_at(b + 13, 1'b0, 1'b1, 1'b0, 6'd0);
                drive_at(b + 15, 1'b1, 1'b0, 1'b0, 6'd0);
                drive_at(b + 21, 1'b1, 1'b0, 1'b0, 6'd32);
                drive_at(b + 23, 1'b1, 1'b0, 1'b0, 6'd0);
            end
            while (q.size() > 0) begin
                @(negedge clk);
                while (q.size() > 0 && q[0].at <= cyc) begin
                    e = q.pop_front();
                    checks++;
                    if ({remaining, running, alert, alert_blink} !== e.val || e.at != cyc) begin
                        errors++;
                        $display("FAIL %s cyc=%0d got=%h exp=%h", e.name, cyc,
                                 {remaining, running, alert, alert_blink}, e.val);
                    end
                end
            end
        join
    endtask

    task automatic test_async_reset;
        exp_t e;
        int b;
        b = cyc + 2;
        expect_at("ar_expire", b + 12, pk(0, 0, 1, 0));
        expect_at("ar_blink", b + 16, pk(0, 0, 1, 1));
        fork
            drive_at(b, 1'b1, 1'b0, 1'b0, 6'd1);
            while (q.size() > 0) begin
                @(negedge clk);
                while (q.size() > 0 && q[0].at <= cyc) begin
                    e = q.pop_front();
                    checks++;
                    if ({remaining, running, alert, alert_blink} !== e.val || e.at != cyc) begin
                        errors++;
                        $display("FAIL %s cyc=%0d got=%h exp=%h", e.name, cyc,
                                 {remaining, running, alert, alert_blink}, e.val);
                    end
                end
            end
        join
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({remaining, running, alert, alert_blink} !== 9'h000) begin
            errors++;
            $display("FAIL async_clear got=%h exp=%h",
                     {remaining, running, alert, alert_blink}, 9'h000);
        end
        @(negedge clk);
        reset_n = 1'b1;
        b = cyc + 1;
        expect_at("post_reset_start", b, pk(2, 1, 0, 0));
        expect_at("post_reset_pre", b + 11, pk(2, 1, 0, 0));
        expect_at("post_reset_dec", b + 12, pk(1, 1, 0, 0));
        fork
            drive_at(b, 1'b1, 1'b0, 1'b0, 6'd2);
            while (q.size() > 0) begin
                @(negedge clk);
                while (q.size() > 0 && q[0].at <= cyc) begin
                    e = q.pop_front();
                    checks++;
                    if ({remaining, running, alert, alert_blink} !== e.val || e.at != cyc) begin
                        errors++;
                        $display("FAIL %s cyc=%0d got=%h exp=%h", e.name, cyc,
                                 {remaining, running, alert, alert_blink}, e.val);
                    end
                end
            end
        join
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ack_rearm();
        test_priority();
        test_restart_on_tick();
        test_clamp_zero();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
